// File: rtl/rs_encoder_stream.sv
// Streaming systematic RS encoder; RS_ENC_SHORTEN_EN allows in_last to end a block early.
// Latency: an accepted symbol is on out_data after that edge; parity follows back to back.
// Backpressure: out_ready=0 freezes the output register, FSM, counters and LFSR.
module rs_encoder_stream #(
    parameter int          M         = 8,
    parameter int          T         = 16,
    parameter int          K         = 223,
    parameter int unsigned PRIM_POLY = 'h11D,
    parameter int          FCR       = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [M-1:0] out_data,
    output logic         out_valid,
    output logic         out_sop,
    output logic         out_eop,
    input  logic         out_ready,
    output logic         len_err,
    output logic         busy
);
    localparam int NP = 2 * T;
    localparam int CW = $clog2(K + 1);
    localparam int PW = $clog2(NP);
    localparam logic [M-1:0] PRED = M'(PRIM_POLY);

    typedef logic [NP-1:0][M-1:0] par_t;
    typedef enum logic {MSG, PAR} state_t;

    function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
        return a[M-1] ? ((a << 1) ^ PRED) : (a << 1);
    endfunction

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        logic [M-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Monic generator, expanded one root at a time; the x^2T term is implicit.
    function automatic par_t gen_poly();
        logic [NP:0][M-1:0] g;
        logic [M-1:0]       root;
        g    = '0;
        g[0] = M'(1);
        root = M'(1);
        for (int e = 0; e < FCR; e++) root = xtime(root);
        for (int i = 0; i < NP; i++) begin
            for (int j = NP; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
            root = xtime(root);
        end
        return g[NP-1:0];
    endfunction

    localparam par_t GEN = gen_poly();

    state_t        state_q, state_d;
    logic [CW-1:0] count_q;
    logic [PW-1:0] pcnt_q;
    par_t          r_q, r_msg, r_par;
    logic          load, accept, k_hit, blk_end, par_end, len_bad;
    logic [M-1:0]  fb;

    always_comb begin
        load     = !out_valid || out_ready;
        in_ready = rst && (state_q == MSG) && load;
        accept   = in_valid && in_ready;
        k_hit    = (count_q == CW'(K - 1));
`ifdef RS_ENC_SHORTEN_EN
        blk_end  = accept && (in_last || k_hit);
        len_bad  = accept && k_hit && !in_last;
`else
        // Fixed length: in_last must coincide exactly with the K-th symbol.
        blk_end  = accept && k_hit;
        len_bad  = accept && (k_hit != in_last);
`endif
        par_end  = (state_q == PAR) && load && (pcnt_q == PW'(NP - 1));

        state_d = state_q;
        case (state_q)
            MSG: if (blk_end) state_d = PAR;
            PAR: if (par_end) state_d = MSG;
        endcase

        fb       = in_data ^ r_q[NP-1];
        r_msg[0] = gf_mul(fb, GEN[0]);
        r_par[0] = '0;
        for (int i = 1; i < NP; i++) begin
            r_msg[i] = r_q[i-1] ^ gf_mul(fb, GEN[i]);
            r_par[i] = r_q[i-1];
        end
    end

    assign busy = (count_q != '0) || (state_q == PAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MSG;
            count_q   <= '0;
            pcnt_q    <= '0;
            r_q       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_err <= len_bad;
            if (accept) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
                out_sop   <= (count_q == '0);
                out_eop   <= 1'b0;
                r_q       <= r_msg;
                count_q   <= blk_end ? '0 : count_q + 1'b1;
            end else if ((state_q == PAR) && load) begin
                // Shifting zeros in leaves the LFSR clear for the next block.
                out_data  <= r_q[NP-1];
                out_valid <= 1'b1;
                out_sop   <= 1'b0;
                out_eop   <= par_end;
                r_q       <= r_par;
                pcnt_q    <= par_end ? '0 : pcnt_q + 1'b1;
            end else if (load) begin
                out_valid <= 1'b0;
                out_sop   <= 1'b0;
                out_eop   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rs_encoder_stream.sv
// Bench for rs_encoder_stream: RS(15,11)-style instance checked against a polynomial-division
// model with random backpressure, plus a default-parameter all-zero block.
module tb_rs_encoder_stream;
    localparam int M    = 4;
    localparam int T    = 2;
    localparam int NP   = 2 * T;
    localparam int K    = 11;
    localparam int NSYM = 15;
    localparam int FCR  = 0;
    localparam int PRIM = 'h13;
`ifdef RS_ENC_SHORTEN_EN
    localparam int UL = 1;
`else
    localparam int UL = K;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [M-1:0] in_data;
    logic         in_valid, in_last, in_ready;
    logic [M-1:0] out_data;
    logic         out_valid, out_sop, out_eop, len_err, busy;
    logic         out_ready = 1'b1;

    logic [7:0] d_in_data, d_out_data;
    logic       d_in_valid, d_in_last, d_in_ready;
    logic       d_out_valid, d_out_sop, d_out_eop, d_len_err, d_busy;

    rs_encoder_stream #(.M(M), .T(T), .K(K), .PRIM_POLY(PRIM), .FCR(FCR)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
        .out_eop(out_eop), .out_ready(out_ready), .len_err(len_err), .busy(busy)
    );

    rs_encoder_stream u_def (
        .clk(clk), .rst(rst), .in_data(d_in_data), .in_valid(d_in_valid), .in_last(d_in_last),
        .in_ready(d_in_ready), .out_data(d_out_data), .out_valid(d_out_valid), .out_sop(d_out_sop),
        .out_eop(d_out_eop), .out_ready(1'b1), .len_err(d_len_err), .busy(d_busy)
    );

    typedef struct {int dat; int sop; int eop; int cyc;} rec_t;
    rec_t cap_q[$];
    rec_t exp_q[$];
    rec_t mon_r;

    int checks = 0;
    int errors = 0;
    int exp_t[0:NSYM-1];
    int log_t[0:NSYM];
    int g_tb[0:NP];
    int blk_dat[0:K-1];
    int blk_lst[0:K-1];
    int cyc = 0;
    int lerr_cnt = 0;
    bit rand_rdy = 0;
    bit prev_hold = 0;
    int prev_vec = 0;
    int d_cnt = 0, d_nz = 0, d_first = 0, d_last = 0, d_sop_at = -1, d_eop_at = -1, d_miss = 0;
    int par1[0:3] = '{15, 3, 1, 12};
    int par2[0:3] = '{13, 6, 2, 11};

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % NSYM];
    endfunction

    function automatic int model_len();
`ifdef RS_ENC_SHORTEN_EN
        for (int i = 0; i < K; i++) if (blk_lst[i] != 0) return i + 1;
`endif
        return K;
    endfunction

    function automatic int model_lerr();
        int n;
`ifdef RS_ENC_SHORTEN_EN
        n = (model_len() == K && blk_lst[K-1] == 0) ? 1 : 0;
`else
        n = (blk_lst[K-1] == 0) ? 1 : 0;
        for (int i = 0; i < K - 1; i++) if (blk_lst[i] != 0) n++;
`endif
        return n;
    endfunction

    // Codeword = message, then remainder of m(x)*x^2T divided by g(x), highest degree first.
    task automatic push_expected();
        int   L;
        int   c[0:K+NP-1];
        int   coef;
        rec_t r;
        L = model_len();
        for (int d = 0; d < K + NP; d++) c[d] = 0;
        for (int k = 0; k < L; k++) c[NP + L - 1 - k] = blk_dat[k];
        for (int d = NP + L - 1; d >= NP; d--) begin
            coef = c[d];
            for (int j = 0; j <= NP; j++) c[d - NP + j] = c[d - NP + j] ^ gmul(coef, g_tb[j]);
        end
        for (int k = 0; k < L; k++) begin
            r.dat = blk_dat[k]; r.sop = int'(k == 0); r.eop = 0; r.cyc = 0;
            exp_q.push_back(r);
        end
        for (int j = 0; j < NP; j++) begin
            r.dat = c[NP - 1 - j]; r.sop = 0; r.eop = int'(j == NP - 1); r.cyc = 0;
            exp_q.push_back(r);
        end
    endtask

    task automatic send_block(input int max_gap, input int n);
        int gap;
        int guard;
        bit acc;
        for (int k = 0; k < n; k++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = M'(blk_dat[k]);
            in_last  = (blk_lst[k] != 0);
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 400) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) chk("accept_wait", int'(acc), 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_block(input int max_gap);
        push_expected();
        send_block(max_gap, model_len());
    endtask

    task automatic clear_plan();
        for (int i = 0; i < K; i++) begin
            blk_dat[i] = 0;
            blk_lst[i] = 0;
        end
    endtask

    task automatic make_unit(input int v);
        clear_plan();
        blk_dat[UL-1] = v;
        blk_lst[UL-1] = 1;
    endtask

    task automatic rand_plan();
        int L;
        clear_plan();
        for (int i = 0; i < K; i++) blk_dat[i] = int'($urandom_range(0, NSYM));
`ifdef RS_ENC_SHORTEN_EN
        L = int'($urandom_range(1, K));
        if ($urandom_range(0, 4) != 0) blk_lst[L-1] = 1;
`else
        L = 0;
        for (int i = 0; i < K - 1; i++) blk_lst[i] = int'($urandom_range(0, 9) == 0);
        blk_lst[K-1] = int'($urandom_range(0, 4) != 0);
`endif
    endtask

    task automatic wait_out();
        int guard;
        guard = 0;
        while (cap_q.size() < exp_q.size() && guard < 4000) begin
            @(posedge clk);
            guard++;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic compare_out(input string tag, input int want_lerr, input int lerr0);
        int n;
        chk({tag, "_count"}, cap_q.size(), exp_q.size());
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_dat"}, cap_q[i].dat, exp_q[i].dat);
            chk({tag, "_sop"}, cap_q[i].sop, exp_q[i].sop);
            chk({tag, "_eop"}, cap_q[i].eop, exp_q[i].eop);
        end
        chk({tag, "_len_err"}, lerr_cnt - lerr0, want_lerr);
        chk({tag, "_busy_idle"}, int'(busy), 0);
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic check_parity(input string tag, input int base, input int v);
        if (cap_q.size() >= base + NP)
            for (int j = 0; j < NP; j++)
                chk(tag, cap_q[base + j].dat, (v == 1) ? par1[j] : par2[j]);
    endtask

    always begin
        @(posedge clk);
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (out_valid && out_ready) begin
                mon_r.dat = int'(out_data); mon_r.sop = int'(out_sop);
                mon_r.eop = int'(out_eop);  mon_r.cyc = cyc;
                cap_q.push_back(mon_r);
            end
            if (len_err) lerr_cnt++;
            if (prev_hold) chk("hold_stable", int'({out_valid, out_sop, out_eop, out_data}), prev_vec);
            prev_hold = out_valid && !out_ready;
            prev_vec  = int'({out_valid, out_sop, out_eop, out_data});
            if (d_out_valid) begin
                if (d_cnt == 0) d_first = cyc;
                d_last = cyc;
                if (d_out_data != 8'd0) d_nz++;
                if (d_out_sop) d_sop_at = d_cnt;
                if (d_out_eop) d_eop_at = d_cnt;
                d_cnt++;
            end
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int x;
        int r;
        int lerr0;
        int exp_lerr;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        d_in_valid = 1'b0; d_in_data = '0; d_in_last = 1'b0;

        x = 1;
        log_t[0] = 0;
        for (int i = 0; i < NSYM; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x << 1;
            if ((x & 16) != 0) x = x ^ PRIM;
        end
        for (int j = 0; j <= NP; j++) g_tb[j] = 0;
        g_tb[0] = 1;
        for (int i = 0; i < NP; i++) begin
            r = exp_t[(FCR + i) % NSYM];
            for (int j = NP; j >= 1; j--) g_tb[j] = g_tb[j-1] ^ gmul(g_tb[j], r);
            g_tb[0] = gmul(g_tb[0], r);
        end

        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sop", int'(out_sop), 0);
        chk("rst_out_eop", int'(out_eop), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_len_err", int'(len_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_def_in_ready", int'(d_in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #2 chk("in_ready_after_rst", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Default parameters: 223 zero symbols stream straight through into 32 zero parity.
        d_in_valid = 1'b1;
        for (int i = 0; i < 223; i++) begin
            d_in_last = (i == 222);
            @(negedge clk);
            if (!d_in_ready) d_miss++;
            @(posedge clk);
            #1;
        end
        d_in_valid = 1'b0;
        d_in_last  = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("def_ready_miss", d_miss, 0);
        chk("def_out_count", d_cnt, 255);
        chk("def_nonzero", d_nz, 0);
        chk("def_sop_pos", d_sop_at, 0);
        chk("def_eop_pos", d_eop_at, 254);
        chk("def_contiguous", d_last - d_first + 1, 255);
        chk("def_busy_idle", int'(d_busy), 0);

        // Known vectors back to back: {1}, {2}, {1}; the LFSR must self-clear between blocks.
        lerr0 = lerr_cnt;
        make_unit(1); run_block(0);
        make_unit(2); run_block(0);
        make_unit(1); run_block(0);
        wait_out();
        check_parity("unit1_parity", UL, 1);
        check_parity("unit2_parity", 2 * UL + NP, 2);
        check_parity("unit3_parity", 3 * UL + 2 * NP, 1);
        if (cap_q.size() >= 3 * (UL + NP)) begin
            chk("no_bubble_1", cap_q[UL + NP].cyc, cap_q[UL + NP - 1].cyc + 1);
            chk("no_bubble_2", cap_q[2 * (UL + NP)].cyc, cap_q[2 * (UL + NP) - 1].cyc + 1);
        end
        compare_out("unit", 0, lerr0);

        // Random messages with random input gaps and random out_ready.
        rand_rdy = 1'b1;
        lerr0 = lerr_cnt;
        exp_lerr = 0;
        for (int b = 0; b < 20; b++) begin
            rand_plan();
            exp_lerr += model_lerr();
            run_block(2);
        end
        wait_out();
        compare_out("rand", exp_lerr, lerr0);
        rand_rdy = 1'b0;

        // Full-length block without in_last flags a length error in every build.
        lerr0 = lerr_cnt;
        rand_plan();
        for (int i = 0; i < K; i++) blk_lst[i] = 0;
        run_block(0);
        wait_out();
        chk("nolast_cw_len", cap_q.size(), K + NP);
        compare_out("nolast", 1, lerr0);

        // in_last on symbol 5 (and on symbol K).
        lerr0 = lerr_cnt;
        rand_plan();
        for (int i = 0; i < K; i++) blk_lst[i] = 0;
        blk_lst[4] = 1;
        blk_lst[K-1] = 1;
        run_block(0);
        wait_out();
`ifdef RS_ENC_SHORTEN_EN
        chk("early_cw_len", cap_q.size(), 5 + NP);
        compare_out("early", 0, lerr0);
`else
        chk("early_cw_len", cap_q.size(), K + NP);
        compare_out("early", 1, lerr0);
`endif

        // Reset in the middle of a block, then a clean known block.
        rand_plan();
        for (int i = 0; i < K; i++) blk_lst[i] = 0;
        send_block(0, 6);
        rst = 1'b0;
        #2;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_eop", int'(out_eop), 0);
        @(posedge clk);
        #1;
        chk("midrst_hold_valid", int'(out_valid), 0);
        rst = 1'b1;
        cap_q.delete();
        exp_q.delete();
        lerr0 = lerr_cnt;
        make_unit(1);
        run_block(0);
        wait_out();
        check_parity("post_rst_parity", UL, 1);
        compare_out("post_rst", 0, lerr0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
